komandara_md_unit: RTL and testbench



---
 rtl/komandara_md_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_komandara_md_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/komandara_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : komandara_md_unit
// Brief    : RISC-V M-extension multiply/divide unit with valid/ready handshakes,
//            tag passthrough, flush, and a radix-configurable restoring divider.
// Revision : 1.0 - initial release
// ============================================================================

package komandara_md_pkg;
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;
endpackage

module komandara_md_unit
    import komandara_md_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DIV_BITS    = 1,
    parameter int MUL_LATENCY = 1,
    parameter int TAG_W       = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  md_op_e           i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [XLEN-1:0]  o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);

    localparam int c_steps = XLEN / DIV_BITS;
    localparam int c_cnt_w = $clog2(c_steps) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);
    localparam logic [XLEN-1:0]    c_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_CALC = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e r_state, w_state_nxt, w_acc_state;

    logic             r_valid, r_busy;
    logic [XLEN-1:0]  r_data;
    logic [TAG_W-1:0] r_tag;

    logic w_accept;
    logic w_is_mul, w_div_signed, w_rem_op, w_div_zero, w_div_ovf, w_fast;
    logic [XLEN-1:0] w_fast_res, w_abs_a, w_abs_b;

    assign o_req_ready = !i_rst && !i_flush &&
                         ((r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready));
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_is_mul     = !i_op[2];
    assign w_div_signed = (i_op == MD_DIV) || (i_op == MD_REM);
    assign w_rem_op     = i_op[1];
    assign w_div_zero   = (i_b == '0);
    assign w_div_ovf    = w_div_signed && (i_a == c_min) && (i_b == '1);
    assign w_fast       = w_div_zero || w_div_ovf;
    assign w_fast_res   = w_div_zero ? (w_rem_op ? i_a : '1) : (w_rem_op ? '0 : i_a);
    assign w_abs_a      = (w_div_signed && i_a[XLEN-1]) ? -i_a : i_a;
    assign w_abs_b      = (w_div_signed && i_b[XLEN-1]) ? -i_b : i_b;

    // Multiplier operand source: live request (latency 1) or staged copy (latency 2)
    logic [XLEN-1:0] w_ma, w_mb;
    logic            w_mhi, w_mas, w_mbs;

    generate
        if (MUL_LATENCY == 2) begin : g_mul_lat2
            logic [XLEN-1:0] r_ma, r_mb;
            logic            r_mhi, r_mas, r_mbs;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ma  <= '0;
                    r_mb  <= '0;
                    r_mhi <= 1'b0;
                    r_mas <= 1'b0;
                    r_mbs <= 1'b0;
                end else if (w_accept && w_is_mul) begin
                    r_ma  <= i_a;
                    r_mb  <= i_b;
                    r_mhi <= (i_op != MD_MUL);
                    r_mas <= (i_op == MD_MULH) || (i_op == MD_MULHSU);
                    r_mbs <= (i_op == MD_MULH);
                end
            end

            assign w_ma  = r_ma;
            assign w_mb  = r_mb;
            assign w_mhi = r_mhi;
            assign w_mas = r_mas;
            assign w_mbs = r_mbs;
        end else begin : g_mul_lat1
            assign w_ma  = i_a;
            assign w_mb  = i_b;
            assign w_mhi = (i_op != MD_MUL);
            assign w_mas = (i_op == MD_MULH) || (i_op == MD_MULHSU);
            assign w_mbs = (i_op == MD_MULH);
        end
    endgenerate

    // Sign-extended to 2*XLEN, a modular product yields the correct high half
    logic [2*XLEN-1:0] w_wide_a, w_wide_b, w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_wide_a  = {{XLEN{w_mas & w_ma[XLEN-1]}}, w_ma};
    assign w_wide_b  = {{XLEN{w_mbs & w_mb[XLEN-1]}}, w_mb};
    assign w_prod    = w_wide_a * w_wide_b;
    assign w_mul_res = w_mhi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    logic [XLEN-1:0]    r_quot, r_rem, r_dvs;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_q_neg, r_r_neg, r_rem_sel;
    logic [XLEN-1:0]    w_q, w_r, w_div_res;
    logic [XLEN:0]      w_trial;

    // DIV_BITS chained restoring steps; dividend bits shift out of r_quot as quotient bits shift in
    always_comb begin
        w_q     = r_quot;
        w_r     = r_rem;
        w_trial = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            w_trial = {w_r, w_q[XLEN-1]} - {1'b0, r_dvs};
            if (w_trial[XLEN]) begin
                w_r = {w_r[XLEN-2:0], w_q[XLEN-1]};
            end else begin
                w_r = w_trial[XLEN-1:0];
            end
            w_q = {w_q[XLEN-2:0], !w_trial[XLEN]};
        end
    end

    assign w_div_res = r_rem_sel ? (r_r_neg ? -w_r : w_r) : (r_q_neg ? -w_q : w_q);

    always_comb begin
        w_acc_state = S_CALC;
        if (w_is_mul) begin
            w_acc_state = (MUL_LATENCY == 2) ? S_MUL : S_RESP;
        end else if (w_fast) begin
            w_acc_state = S_RESP;
        end

        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_nxt = w_acc_state;
                S_MUL:  w_state_nxt = S_RESP;
                S_CALC: if (r_cnt == c_last) w_state_nxt = S_RESP;
                S_RESP: if (i_rsp_ready) w_state_nxt = w_accept ? w_acc_state : S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == S_RESP);
            r_busy  <= (w_state_nxt == S_MUL) || (w_state_nxt == S_CALC);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data    <= '0;
            r_tag     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_rem_sel <= 1'b0;
        end else if (!i_flush) begin
            if (w_accept) begin
                r_tag <= i_tag;
                if (w_is_mul) begin
                    if (MUL_LATENCY == 1) r_data <= w_mul_res;
                end else if (w_fast) begin
                    r_data <= w_fast_res;
                end else begin
                    r_quot    <= w_abs_a;
                    r_dvs     <= w_abs_b;
                    r_rem     <= '0;
                    r_cnt     <= '0;
                    r_q_neg   <= w_div_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
                    r_r_neg   <= w_div_signed && i_a[XLEN-1];
                    r_rem_sel <= w_rem_op;
                end
            end else if (r_state == S_MUL) begin
                r_data <= w_mul_res;
            end else if (r_state == S_CALC) begin
                r_quot <= w_q;
                r_rem  <= w_r;
                r_cnt  <= r_cnt + c_cnt_w'(1);
                if (r_cnt == c_last) r_data <= w_div_res;
            end
        end
    end

    assign o_rsp_valid = r_valid;
    assign o_rsp_data  = r_data;
    assign o_rsp_tag   = r_tag;
    assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_komandara_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_komandara_md_unit
// Brief    : Scoreboard bench for komandara_md_unit (32-bit radix-4 / 64-bit radix-16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_komandara_md_unit;
    import komandara_md_pkg::*;

    localparam int W0 = 32, DB0 = 2, ML0 = 1;
    localparam int W1 = 64, DB1 = 4, ML1 = 2;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        int          dec;
        int          lat;
        int          busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    bit   has_cur[2];
    bit   prev_v[2];
    bit   prev_hs[2];
    int   bcnt[2];

    int total = 0, bad = 0, cyc = 0;
    bit rnd_mode = 0;

    logic clk = 0, rst = 1, rsp_ready = 1;
    logic req_valid0 = 0, req_valid1 = 0, flush0 = 0, flush1 = 0;
    md_op_e op = MD_MUL;
    logic [63:0] a = '0, b = '0;
    logic [4:0]  tag = '0;

    logic        rdy0, valid0, busy0, rdy1, valid1, busy1;
    logic [31:0] data0;
    logic [63:0] data1;
    logic [4:0]  tag0, tag1;

    komandara_md_unit #(.XLEN(W0), .DIV_BITS(DB0), .MUL_LATENCY(ML0), .TAG_W(5)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid0), .o_req_ready(rdy0),
        .i_op(op), .i_a(a[31:0]), .i_b(b[31:0]), .i_tag(tag), .i_flush(flush0),
        .o_rsp_valid(valid0), .i_rsp_ready(rsp_ready), .o_rsp_data(data0),
        .o_rsp_tag(tag0), .o_busy(busy0)
    );

    komandara_md_unit #(.XLEN(W1), .DIV_BITS(DB1), .MUL_LATENCY(ML1), .TAG_W(5)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid1), .o_req_ready(rdy1),
        .i_op(op), .i_a(a), .i_b(b), .i_tag(tag), .i_flush(flush1),
        .o_rsp_valid(valid1), .i_rsp_ready(rsp_ready), .o_rsp_data(data1),
        .o_rsp_tag(tag1), .o_busy(busy1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h need %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact arithmetic on wide signed integers, result truncated to w bits
    function automatic logic [63:0] model(input int w, input md_op_e o,
                                          input logic [63:0] ia, input logic [63:0] ib);
        logic signed [129:0] mask, ua, ub, sa, sb, r;
        mask = (130'sd1 <<< w) - 130'sd1;
        ua = $signed({66'd0, ia}) & mask;
        ub = $signed({66'd0, ib}) & mask;
        sa = ia[w-1] ? (ua | ~mask) : ua;
        sb = ib[w-1] ? (ub | ~mask) : ub;
        case (o)
            MD_MUL:    r = sa * sb;
            MD_MULH:   r = (sa * sb) >>> w;
            MD_MULHSU: r = (sa * ub) >>> w;
            MD_MULHU:  r = (ua * ub) >>> w;
            MD_DIV:    r = (ub == 0) ? mask : sa / sb;
            MD_DIVU:   r = (ub == 0) ? mask : ua / ub;
            MD_REM:    r = (ub == 0) ? ua : sa % sb;
            default:   r = (ub == 0) ? ua : ua % ub;
        endcase
        r = r & mask;
        return r[63:0];
    endfunction

    function automatic int exp_lat(input int d, input md_op_e o, input logic [63:0] ia,
                                   input logic [63:0] ib, output int bz);
        int          w    = (d == 1) ? W1 : W0;
        int          ml   = (d == 1) ? ML1 : ML0;
        int          n    = (d == 1) ? (W1 / DB1) : (W0 / DB0);
        logic [63:0] mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        logic [63:0] mn   = 64'd1 << (w - 1);
        if (o inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU}) begin
            bz = ml - 1;
            return ml;
        end
        if ((ib & mask) == 0 ||
            ((o == MD_DIV || o == MD_REM) && (ia & mask) == mn && (ib & mask) == mask)) begin
            bz = 0;
            return 1;
        end
        bz = n;
        return n + 1;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = mask;
            2: v = 64'd1 << (w - 1);
            3: v = 64'($urandom_range(1, 15));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    // Monitor step: first cycle of each response pops the scoreboard
    task automatic mon(input int d, input logic v, input logic bz, input logic rr, input logic fl,
                       input logic [63:0] data, input logic [4:0] tg);
        bit first;
        first = v && (!prev_v[d] || prev_hs[d]);
        if (first) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                total++;
                bad++;
                has_cur[d] = 0;
                $display("FAIL unexpected_rsp dut%0d: got data %h need no response", d, data);
            end else begin
                cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
                has_cur[d] = 1;
                chk($sformatf("latency dut%0d", d), 64'(cyc - cur[d].dec), 64'(cur[d].lat));
                chk($sformatf("busy_cycles dut%0d", d), 64'(bcnt[d]), 64'(cur[d].busy));
            end
            bcnt[d] = 0;
        end
        if (v && has_cur[d]) begin
            chk($sformatf("rsp_data dut%0d", d), data, cur[d].data);
            chk($sformatf("rsp_tag dut%0d", d), 64'(tg), 64'(cur[d].tag));
            chk($sformatf("req_ready_in_resp dut%0d", d), 64'(rr), 64'(rsp_ready && !fl && !rst));
            chk($sformatf("busy_in_resp dut%0d", d), 64'(bz), 64'd0);
        end
        if (bz === 1'b1) bcnt[d]++;
        if (fl || rst) bcnt[d] = 0;
        prev_hs[d] = v && rsp_ready && !fl && !rst;
        prev_v[d]  = v;
    endtask

    initial forever begin
        @(negedge clk);
        mon(0, valid0, busy0, rdy0, flush0, {32'd0, data0}, tag0);
        mon(1, valid1, busy1, rdy1, flush1, data1, tag1);
    end

    task automatic issue(input int d, input md_op_e o, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [4:0] t, input logic [63:0] e, input bit push,
                         input bit set_ready, output int waited);
        exp_t x;
        int   bz;
        bit   ok;
        @(posedge clk);
        #1;
        op = o; a = ia; b = ib; tag = t;
        if (set_ready) rsp_ready = 1;
        if (d == 0) req_valid0 = 1; else req_valid1 = 1;
        waited = 0;
        ok = 0;
        while (!ok && waited <= 400) begin
            @(negedge clk);
            if ((d == 0 ? rdy0 : rdy1) === 1'b1) ok = 1;
            else waited++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut%0d: waited %0d need <= 400", d, waited);
            req_valid0 = 0;
            req_valid1 = 0;
        end else if (push) begin
            x.data = e;
            x.tag  = t;
            x.dec  = cyc;
            x.lat  = exp_lat(d, o, ia, ib, bz);
            x.busy = bz;
            if (d == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req_valid0 = 0;
        req_valid1 = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || valid0 || valid1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_cycles_exceeded", 64'(n >= 300), 64'd0);
    endtask

    task automatic kill_div(input bit use_rst);
        int w;
        issue(0, MD_DIV, 64'd1000, 64'd3, 5'd3, 64'd0, 0, 0, w);
        idle();
        repeat (5) @(posedge clk);
        #1;
        if (use_rst) rst = 1; else flush0 = 1;
        req_valid0 = 1; op = MD_MUL; a = 64'd2; b = 64'd2; tag = 5'd4;
        @(negedge clk);
        chk("req_ready_during_kill", 64'(rdy0), 64'd0);
        @(posedge clk);
        #1;
        rst = 0; flush0 = 0; req_valid0 = 0;
        @(negedge clk);
        chk("req_ready_after_kill", 64'(rdy0), 64'd1);
        chk("valid_after_kill", 64'(valid0), 64'd0);
        issue(0, MD_MUL, 64'd6, 64'd7, 5'd5, 64'd42, 1, 0, w);
        idle();
        drain();
    endtask

    initial begin
        int w;
        md_op_e o;
        logic [63:0] ra, rb;
        logic [4:0] rt;

        repeat (2) @(negedge clk);
        chk("req_ready_in_reset", 64'(rdy0), 64'd0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset_valid", 64'(valid0), 64'd0);
        chk("reset_data", 64'(data0), 64'd0);
        chk("reset_tag", 64'(tag0), 64'd0);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_ready", 64'(rdy0), 64'd1);
        chk("reset_data_dut1", data1, 64'd0);

        // Signed divide/remainder, normal path
        issue(0, MD_DIV, 64'hFFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFD, 1, 0, w); idle(); drain();
        issue(0, MD_REM, 64'hFFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF, 1, 0, w); idle(); drain();

        // Fast-path divides
        issue(0, MD_DIVU, 64'h1234, 64'd0, 5'd3, 64'hFFFF_FFFF, 1, 0, w);
        issue(0, MD_REMU, 64'h1234, 64'd0, 5'd4, 64'h1234, 1, 0, w);
        issue(0, MD_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 64'h8000_0000, 1, 0, w);
        issue(0, MD_REM, 64'h8000_0000, 64'hFFFF_FFFF, 5'd6, 64'd0, 1, 0, w);
        idle(); drain();

        // Back-to-back multiplies at full rate
        issue(0, MD_MULH, 64'h8000_0000, 64'h8000_0000, 5'd7, 64'h4000_0000, 1, 0, w);
        issue(0, MD_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd8, 64'hFFFF_FFFF, 1, 0, w);
        chk("mul_b2b_wait_1", 64'(w), 64'd0);
        issue(0, MD_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd9, 64'hFFFF_FFFE, 1, 0, w);
        chk("mul_b2b_wait_2", 64'(w), 64'd0);
        issue(0, MD_MUL, 64'd3, 64'd4, 5'd10, 64'd12, 1, 0, w);
        chk("mul_b2b_wait_3", 64'(w), 64'd0);
        idle(); drain();

        // Backpressure, then response and new request on one edge
        @(posedge clk); #1; rsp_ready = 0;
        issue(0, MD_DIVU, 64'd100, 64'd7, 5'd9, 64'd14, 1, 0, w); idle();
        w = 0;
        while (!valid0 && w < 100) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        issue(0, MD_MUL, 64'd5, 64'd5, 5'd11, 64'd25, 1, 1, w);
        chk("same_edge_accept_wait", 64'(w), 64'd0);
        idle(); drain();

        kill_div(0);
        kill_div(1);

        // 64-bit instance, radix-16 divider, two-cycle multiplier
        issue(1, MD_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd12, 64'h5555_5555_5555_5555, 1, 0, w);
        idle(); drain();
        issue(1, MD_REM, 64'h8000_0000_0000_0001, 64'd10, 5'd13, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0, w);
        idle(); drain();
        issue(1, MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14,
              64'hFFFF_FFFF_FFFF_FFFE, 1, 0, w);
        idle(); drain();

        // Randomized traffic with random backpressure
        rnd_mode = 1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60; i++) begin
                o  = md_op_e'($urandom_range(0, 7));
                ra = pick(d == 1 ? W1 : W0);
                rb = pick(d == 1 ? W1 : W0);
                rt = 5'($urandom);
                issue(d, o, ra, rb, rt, model(d == 1 ? W1 : W0, o, ra, rb), 1, 0, w);
                if ($urandom_range(0, 2) == 0) idle();
            end
            idle();
            drain();
        end
        rnd_mode = 0;
        @(posedge clk); #1; rsp_ready = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
